// File: rtl/matrix_obi_pkg.sv
// Shared OBI types and width helpers for the matrix LSU request/grant/rvalid channel.
package matrix_obi_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;

  typedef struct packed {
    logic                      req;
    logic [31:0]               addr;
    logic                      we;
    logic [BYTES_PER_WORD-1:0] be;
    logic [DATA_WIDTH-1:0]     wdata;
  } obi_req_t;

  typedef struct packed {
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } obi_rsp_t;

  // Number of byte lanes for an arbitrary bus width.
  function automatic int unsigned bytes_per_word(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/matrix_obi_rsp_pipe.sv
// Fixed-latency response pipe: every accepted transaction emerges LATENCY cycles later.
// The initiator cannot backpressure rvalid, so the pipe shifts every cycle.
module matrix_obi_rsp_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid,
  input  logic                  in_err,
  input  logic [DATA_WIDTH-1:0] in_rdata,
  output logic                  out_valid,
  output logic                  out_err,
  output logic [DATA_WIDTH-1:0] out_rdata
);

  logic [LATENCY-1:0]    valid_q;
  logic [LATENCY-1:0]    err_q;
  logic [DATA_WIDTH-1:0] rdata_q [LATENCY];

  // Shift all stages each cycle; reset discards anything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      err_q[0]   <= in_err;
      rdata_q[0] <= in_rdata;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        rdata_q[i] <= rdata_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_err   = err_q[LATENCY-1];
  assign out_rdata = rdata_q[LATENCY-1];

endmodule

// File: rtl/matrix_obi_mem_responder.sv
// OBI responder modelling a single-port, word-addressed, byte-enabled SRAM bank
// with fixed read latency and a cap on granted-but-unanswered transactions.
//
// Handshake: a transaction is accepted in the cycle where req_i and gnt_o are both
// high; gnt_o is combinational and may depend on req_i. Exactly one rvalid_o pulse
// answers each accepted transaction, LATENCY cycles later, strictly in order.
// rdata_o/err_o are meaningful only while rvalid_o is high. rvalid has no ready.
module matrix_obi_mem_responder
  import matrix_obi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NUM_WORDS       = 256,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic [31:0]             addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  input  logic                    stall_i
);

  localparam int unsigned          BPW     = bytes_per_word(DATA_WIDTH);
  localparam int unsigned          OFF_W   = $clog2(BPW);
  localparam int unsigned          IDX_W   = $clog2(NUM_WORDS);
  localparam int unsigned          CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [32:0]          SPAN    = 33'(NUM_WORDS) * 33'(BPW);
  localparam logic [CNT_W-1:0]     MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]           offset;
  logic                  in_range;
  logic [IDX_W-1:0]      index;
  logic                  accept;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

  // Decode, grant and the response payload captured at accept time.
  always_comb begin
    offset    = addr_i - BASE_ADDR;
    in_range  = ({1'b0, offset} < SPAN);
    index     = offset[OFF_W +: IDX_W];
    // A response retiring this cycle frees its slot for a new grant.
    gnt_o     = req_i & ~stall_i & ((cnt_q < MAX_CNT) | rvalid_o);
    accept    = req_i & gnt_o;
    rsp_err   = accept & ~in_range;
    rsp_rdata = '0;
    if (accept && !we_i && in_range) begin
      rsp_rdata = mem_q[index];
    end
  end

  // Byte-lane writes; storage keeps its contents across reset.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && in_range) begin
      for (int b = 0; b < BPW; b++) begin
        if (be_i[b]) begin
          mem_q[index][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Outstanding count: up on accept, down on response, unchanged on both.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      case ({accept, rvalid_o})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  matrix_obi_rsp_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .LATENCY   (LATENCY)
  ) u_rsp_pipe (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .in_valid (accept),
    .in_err   (rsp_err),
    .in_rdata (rsp_rdata),
    .out_valid(rvalid_o),
    .out_err  (err_o),
    .out_rdata(rdata_o)
  );

endmodule

// File: tb/tb_matrix_obi_mem_responder.sv
// Bench for matrix_obi_mem_responder: directed scenarios followed by randomized
// traffic, checked against a transaction-level model (word array + response queue).
module tb_matrix_obi_mem_responder;
  import matrix_obi_pkg::*;

  localparam int unsigned LAT  = 3;
  localparam int unsigned MAXO = 2;
  localparam int unsigned NW   = 256;
  localparam logic [31:0] BASE = 32'h1000_0000;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic        req, we, stall, gnt, rvalid, err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;

  matrix_obi_mem_responder #(
    .DATA_WIDTH     (32),
    .NUM_WORDS      (NW),
    .BASE_ADDR      (BASE),
    .LATENCY        (LAT),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .req_i   (req),
    .addr_i  (addr),
    .we_i    (we),
    .be_i    (be),
    .wdata_i (wdata),
    .gnt_o   (gnt),
    .rvalid_o(rvalid),
    .rdata_o (rdata),
    .err_o   (err),
    .stall_i (stall)
  );

  // Scoreboard / reference model
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  logic [31:0] mem_m [NW];
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int unsigned due_q[$];

  // Initiator-side hold tracking (request must stay stable until granted)
  logic     held = 1'b0;
  obi_req_t held_req;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check at negedge, update model, advance to posedge+1.
  task automatic step(input logic rq, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d, input logic st,
                      output logic granted);
    logic        exp_rv, exp_gnt, in_r;
    int unsigned outstanding, idx;
    logic [31:0] off, rd;
    obi_req_t    cur;
    cur = '{req: rq, addr: a, we: w, be: b, wdata: d};
    if (held) begin
      check("req_stable", cur, held_req);
    end
    req = rq; we = w; addr = a; be = b; wdata = d; stall = st;
    @(negedge clk);
    outstanding = due_q.size();
    exp_rv = (outstanding > 0) && (due_q[0] == cyc);
    check("rvalid", {31'b0, rvalid}, {31'b0, exp_rv});
    if (exp_rv) begin
      check("rdata", rdata, exp_q[0]);
      check("err", {31'b0, err}, {31'b0, exp_err_q[0]});
      void'(exp_q.pop_front());
      void'(exp_err_q.pop_front());
      void'(due_q.pop_front());
    end
    exp_gnt = rq && !st && ((outstanding < MAXO) || exp_rv);
    check("gnt", {31'b0, gnt}, {31'b0, exp_gnt});
    granted = exp_gnt;
    held = rq && !exp_gnt;
    held_req = cur;
    if (exp_gnt) begin
      off  = a - BASE;
      in_r = (off < NW * 4);
      idx  = off / 4;
      rd   = 32'h0;
      if (in_r && w) begin
        for (int k = 0; k < 4; k++) begin
          if (b[k]) mem_m[idx][8*k +: 8] = d[8*k +: 8];
        end
      end else if (in_r) begin
        rd = mem_m[idx];
      end
      exp_q.push_back(rd);
      exp_err_q.push_back(!in_r);
      due_q.push_back(cyc + LAT);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int unsigned n);
    logic g;
    repeat (n) step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, g);
  endtask

  // Present one transaction until granted, with an optional random stall rate.
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input int unsigned stall_pct);
    logic        g, st;
    int unsigned n;
    g = 1'b0;
    n = 0;
    while (!g && n < 64) begin
      st = ($urandom_range(99) < stall_pct);
      step(1'b1, w, a, b, d, st, g);
      n++;
    end
    if (!g) begin
      vectors++;
      miscompares++;
      $error("FAIL grant_timeout observed=%0d cycles expected<64", n);
    end
  endtask

  // Reset while responses are in flight; outputs must clear immediately.
  task automatic do_reset();
    req = 1'b0; we = 1'b0; stall = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("rst_rvalid", {31'b0, rvalid}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    exp_q.delete();
    exp_err_q.delete();
    due_q.delete();
    held = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    cyc += 2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        g;
    logic [31:0] a;
    req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; stall = 1'b0;

    // Power-up reset
    repeat (2) @(posedge clk);
    check("por_rvalid", {31'b0, rvalid}, 32'h0);
    check("por_rdata", rdata, 32'h0);
    check("por_err", {31'b0, err}, 32'h0);
    #1;
    rst_ni = 1'b1;
    idle(2);

    // Preload words 0..15
    for (int w = 0; w < 16; w++) do_txn(1'b1, BASE + 32'(w * 4), 4'hF, $urandom, 0);
    idle(LAT + 1);

    // Write then read back-to-back (read-after-write)
    do_txn(1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, 0);
    do_txn(1'b0, BASE + 32'h10, 4'hF, 32'h0, 0);
    idle(LAT + 1);

    // Byte enables
    do_txn(1'b1, BASE + 32'h14, 4'hF, 32'h1122_3344, 0);
    do_txn(1'b1, BASE + 32'h14, 4'b0101, 32'hAABB_CCDD, 0);
    do_txn(1'b0, BASE + 32'h14, 4'h0, 32'h0, 0);
    idle(LAT + 1);

    // Streaming reads of words 0..7 against the outstanding cap
    for (int w = 0; w < 8; w++) do_txn(1'b0, BASE + 32'(w * 4), 4'hF, 32'h0, 0);
    idle(LAT + 1);

    // Out of range, above the bank and wrapped below the base
    do_txn(1'b0, BASE + NW * 4, 4'hF, 32'h0, 0);
    do_txn(1'b1, BASE + NW * 4, 4'hF, 32'hFFFF_FFFF, 0);
    do_txn(1'b0, BASE - 32'h4, 4'hF, 32'h0, 0);
    do_txn(1'b0, BASE, 4'hF, 32'h0, 0);
    idle(LAT + 1);

    // Stall with request held, then release
    repeat (5) step(1'b1, 1'b0, BASE + 32'hC, 4'hF, 32'h0, 1'b1, g);
    do_txn(1'b0, BASE + 32'hC, 4'hF, 32'h0, 0);
    idle(LAT + 1);

    // Reset with two reads outstanding, then read data written before reset
    do_txn(1'b0, BASE + 32'h4, 4'hF, 32'h0, 0);
    do_txn(1'b0, BASE + 32'h8, 4'hF, 32'h0, 0);
    do_reset();
    do_txn(1'b0, BASE + 32'h4, 4'hF, 32'h0, 0);
    do_txn(1'b0, BASE + 32'h8, 4'hF, 32'h0, 0);
    do_txn(1'b0, BASE + 32'h10, 4'hF, 32'h0, 0);
    idle(LAT + 1);

    // Randomized traffic: misaligned addresses, partial writes, stalls, gaps
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(7) == 0) begin
        a = ($urandom_range(1) == 0) ? BASE + NW * 4 + 32'($urandom_range(255) * 4)
                                     : BASE - 32'($urandom_range(1, 64) * 4);
      end else begin
        a = BASE + 32'($urandom_range(15) * 4) + 32'($urandom_range(3));
      end
      do_txn(1'($urandom_range(1)), a, 4'($urandom_range(15)), $urandom, 20);
      if ($urandom_range(3) == 0) idle($urandom_range(2));
    end
    idle(LAT + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matrix_obi_mem_responder.md
Name: matrix_obi_mem_responder

Overview:
- OBI responder (slave) modelling a single-port, word-addressed, byte-enabled SRAM bank with configurable fixed read latency and an outstanding-request cap.
- Serves the matrix LSU request/grant/rvalid channel: accepts reads and writes from one initiator, returns in-order responses.
- Used in block-level benches and as the scratchpad bank in the matrix subsystem top.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (multiple of 8).
- NUM_WORDS, 256, storage depth in DATA_WIDTH words (power of 2).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- LATENCY, 1, cycles from grant to rvalid (>= 1).
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (>= 1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- req_i  in  1  OBI request
- addr_i  in  32  OBI byte address
- we_i  in  1  1 = write, 0 = read
- be_i  in  DATA_WIDTH/8  byte enables
- wdata_i  in  DATA_WIDTH  write data
- gnt_o  out  1  OBI grant (combinational)
- rvalid_o  out  1  response valid, one per granted request
- rdata_o  out  DATA_WIDTH  read data (valid with rvalid_o)
- err_o  out  1  access error, valid with rvalid_o
- stall_i  in  1  grant inhibit for backpressure injection (tie 0 in silicon)

Behaviour:
- Reset: rvalid_o=0, rdata_o=0, err_o=0, outstanding count=0, response pipe cleared. Storage array is not reset.
- Grant: gnt_o = req_i & ~stall_i & (outstanding < MAX_OUTSTANDING | rvalid_o). Accepted transaction = req_i & gnt_o.
- Address decode: offset = addr_i - BASE_ADDR (32-bit modular). Index = offset >> log2(DATA_WIDTH/8).
- Out of range: offset >= NUM_WORDS*DATA_WIDTH/8. Such an access is accepted, performs no storage access, and responds with err_o=1 and rdata_o=0.
- Misalignment: low offset bits are ignored (word aligned).
- Write: storage updated at the accepted-cycle clock edge, only the lanes with be_i set. Response returns rvalid_o=1, rdata_o=0, err_o per decode.
- Read: storage read at the accept cycle. Data travels down the response pipe. Full word is returned regardless of be_i.
- Read-after-write: a read accepted the cycle after a write to the same word returns the new data.
- Latency: response for a transaction accepted in cycle t appears in cycle t+LATENCY, exactly one cycle wide. Responses are strictly in order, one transaction per cycle max. The initiator has no rvalid backpressure, so the pipe never stalls.
- Outstanding counter: +1 on accept, -1 on rvalid_o, both in the same cycle leave it unchanged. Width clog2(MAX_OUTSTANDING+1). Never exceeds MAX_OUTSTANDING.
- If MAX_OUTSTANDING < LATENCY, throughput is limited to MAX_OUTSTANDING accepts per LATENCY cycles.
- stall_i is sampled combinationally. req_i held while stalled is not a protocol violation. The address and data must stay stable until granted; this is the initiator's obligation and is checked by bench assertion only.
- Reset mid-operation: in-flight responses are discarded and the counter cleared. Storage contents are retained (undefined only at power-up).

Decomposition:
- Package matrix_obi_pkg: obi_req_t (req, addr, we, be, wdata) and obi_rsp_t (gnt, rvalid, rdata, err) typedefs, parameterised by a package DATA_WIDTH constant. Also holds the BYTES_PER_WORD helper constant.
- Sub-module matrix_obi_rsp_pipe: LATENCY-deep shift register of {valid, err, rdata}, asynchronous reset of valid bits. The top instantiates it and holds storage, decode, grant and the counter.

Test Plan:
- Single write then read: write 0xDEADBEEF, be=4'hF, addr BASE+0x10; then read addr 0x10 -> read rvalid at accept+LATENCY, rdata=0xDEADBEEF, err=0; write rvalid with rdata=0.
- Byte enables: preload 0x11223344, write 0xAABBCCDD with be=4'b0101 -> read returns 0x11BB33DD.
- Streaming with LATENCY=3, MAX_OUTSTANDING=2: 8 back-to-back reads of words 0..7 -> gnt pattern 1,1,0,1,1,0,... and rvalid order is words 0..7.
- Out of range: read at BASE+NUM_WORDS*4 -> gnt=1, rvalid with err=1, rdata=0. Write there -> word 0 unchanged.
- Stall: assert stall_i for 5 cycles with req_i high -> gnt_o=0 throughout, no rvalid. Deassert -> grant in the same cycle, response after LATENCY.
- Reset mid-flight: reset while 2 reads are outstanding -> rvalid_o=0 immediately and counter=0. After release, reads return the pre-reset written data.
